ise_param_sorter: RTL and testbench
===================================

# ise_param_sorter

Parametrised image sorting engine for the colour-classification pipeline. Accepts NUM_IMG images of PIX_PER_IMG RGB pixels over a valid/ready stream, classifies every pixel by dominant channel, computes each image's dominant colour and fixed-point average intensity, insertion-sorts images on arrival, then streams the sorted image indices with backpressure.

## Interface
- NUM_IMG, 32, images per batch (≥2)
- PIX_PER_IMG, 16384, pixels per image (≥1)
- CH_W, 8, bits per colour channel
- FRAC_W, 3, fraction bits of the average
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  pixel_in valid
- in_ready  out  1  engine accepts a pixel this cycle
- pixel_in  in  3*CH_W  {R,G,B}, R in MSBs
- out_valid  out  1  sorted entry valid
- out_ready  in  1  sink accepts entry
- color_index  out  2  dominant colour of entry: 0=R, 1=G, 2=B
- image_out_index  out  $clog2(NUM_IMG)  arrival-order index of entry
- out_last  out  1  final entry of the batch
- avg_out  out  CH_W+FRAC_W  average of entry (only with ISE_AVG_OUT_EN)

## Operation
- States: LOAD, DIV, INS, OUT. Reset → LOAD, pixel and image counters 0, sorted list empty.
- Pixel class: R if R≥G and R≥B; else G if G>R and G≥B; else B. Accepted pixel (in_valid&&in_ready) increments that class's count and adds that channel to its sum.
- Count width $clog2(PIX_PER_IMG+1); sum width CH_W+$clog2(PIX_PER_IMG+1); no overflow possible.
- LOAD: in_ready=1. On the PIX_PER_IMG-th accepted pixel → DIV.
- Dominant class (evaluated entering DIV): R if cntR>cntG and cntR>cntB; else G if cntG>cntB and cntG>cntR; else B.
- DIV: avg = floor((sum<<FRAC_W)/cnt) of dominant class, restoring division, one quotient bit per cycle, CH_W+FRAC_W cycles. cnt==0 → avg=0.
- INS: key={type,avg}; entry inserted into the sorted register list in one cycle (parallel compare, shift larger entries up). Ascending key; equal keys keep arrival order (new entry placed after existing equals). Class counters/sums cleared. Image counter +1; if it reaches NUM_IMG → OUT else → LOAD.
- OUT: entry 0 presented; on out_valid&&out_ready list shifts down by one. out_last=1 on entry NUM_IMG-1; its transfer → LOAD, image counter 0, new batch.
- in_ready=0 in DIV, INS, OUT; pixels offered then are not consumed.
- rst at any point aborts the batch; no partial output.

## Timing
- Reset values: in_ready=1, out_valid=0, color_index=0, image_out_index=0, out_last=0, avg_out=0.
- in_ready, out_valid, out_last are decoded from registered state only (no combinational in→out path).
- Per image: PIX_PER_IMG accepted pixels + CH_W+FRAC_W (DIV) + 1 (INS) cycles; in_ready low for CH_W+FRAC_W+1 cycles after the last pixel.
- out_valid rises the cycle after the final INS; with out_ready held high, NUM_IMG consecutive transfers.
- out_ready low: outputs held stable, out_valid stays high.
- in_valid gaps in LOAD stall accumulation with no state change.

## Configuration
- ISE_AVG_OUT_EN defined: avg_out port present, carries the stored average of the presented entry, held with the other outputs.
- Undefined: port absent; averages stored internally for sorting only; all other behaviour identical.

## Structure
- Package ise_pkg: colour codes COLOR_R/G/B, state encoding, key/average width constants derived from CH_W and FRAC_W.
- Sub-module ise_seq_div: start/done restoring divider, parametrised dividend/divisor/quotient widths, divide-by-zero → 0.
- Top holds classifier, accumulators, FSM, sorted list.

## Test plan
- NUM_IMG=4, PIX_PER_IMG=4, FRAC_W=3: image 0 pixels R-dominant R=10,10,10,0xFF0000-free → R sums; image with R sum 10, cnt 3 → avg 26 (3.25 floor); verify avg_out=26.
- Four images: G avg 5, R avg 200, B avg 1, R avg 7 → output index order 3,1,0,2, colours 0,0,1,2, out_last on 4th.
- Image with 2 R, 2 G, 0 B pixels → dominant B, cnt 0, avg 0; sorts as B with key {2,0}.
- Two images equal key → lower arrival index output first.
- out_ready toggled 1,0,0,1 during OUT → each entry held while stalled, no drop/duplicate; in_valid gaps in LOAD → same results as gap-free run.
- rst asserted mid-LOAD of image 2 → in_ready=1, out_valid=0 next cycle; fresh batch sorts correctly.

Source files
------------

// File: rtl/ise_pkg.sv
// Shared definitions for the image sorting engine: colour codes, FSM state
// encoding and helpers that derive the average/key widths from the channel
// width and the number of fraction bits.
package ise_pkg;

    // Colour class codes; also the most significant field of a sort key,
    // so the numeric order R < G < B is the primary sort order.
    localparam logic [1:0] COLOR_R = 2'd0;
    localparam logic [1:0] COLOR_G = 2'd1;
    localparam logic [1:0] COLOR_B = 2'd2;

    localparam int TYPE_W = 2;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_DIV  = 2'd1,
        S_INS  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    // Fixed-point average: integer part CH_W bits, FRAC_W fraction bits.
    function automatic int avg_width(input int ch_w, input int frac_w);
        return ch_w + frac_w;
    endfunction

    // Sort key = {colour, average}.
    function automatic int key_width(input int ch_w, input int frac_w);
        return TYPE_W + ch_w + frac_w;
    endfunction

endpackage

// File: rtl/ise_seq_div.sv
// Start/done restoring divider producing Q_W quotient bits, one per cycle.
// The first quotient bit is produced in the start cycle itself, so done
// pulses exactly Q_W cycles after start, with the quotient valid while done
// is high and held until the next start.
// The caller guarantees (dividend >> Q_W) < divisor whenever divisor != 0,
// i.e. the quotient fits in Q_W bits. A zero divisor yields a zero quotient.
// Requires Q_W >= 2.
module ise_seq_div #(
    parameter int DVD_W = 22,
    parameter int DVS_W = 15,
    parameter int Q_W   = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int CNT_W = $clog2(Q_W + 1);

    logic [DVS_W-1:0] rem_q;
    logic [DVS_W-1:0] dvs_q;
    logic [Q_W-1:0]   shreg_q;
    logic [CNT_W-1:0] cnt_q;
    logic             zero_q;
    logic             done_q;

    logic [DVS_W-1:0] rem_in;
    logic [DVS_W-1:0] dvs_in;
    logic             bit_in;
    logic [DVS_W:0]   trial;
    logic             ge;
    logic [DVS_W-1:0] rem_nxt;
    logic [Q_W-1:0]   shreg_nxt;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_in    = rem_q;
        dvs_in    = dvs_q;
        bit_in    = shreg_q[Q_W-1];
        shreg_nxt = {shreg_q[Q_W-2:0], 1'b0};
        if (start) begin
            rem_in    = DVS_W'(dividend >> Q_W);
            dvs_in    = divisor;
            bit_in    = dividend[Q_W-1];
            shreg_nxt = {dividend[Q_W-2:0], 1'b0};
        end
        trial        = {rem_in, bit_in};
        ge           = (trial >= {1'b0, dvs_in});
        rem_nxt      = ge ? DVS_W'(trial - {1'b0, dvs_in}) : DVS_W'(trial);
        shreg_nxt[0] = ge;
    end

    // Iteration registers: the shift register carries remaining dividend
    // bits out of the top while quotient bits enter at the bottom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q   <= '0;
            dvs_q   <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q   <= rem_nxt;
                dvs_q   <= divisor;
                shreg_q <= shreg_nxt;
                cnt_q   <= CNT_W'(Q_W - 1);
                zero_q  <= (divisor == '0);
            end else if (cnt_q != '0) begin
                rem_q   <= rem_nxt;
                shreg_q <= shreg_nxt;
                cnt_q   <= cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done     = done_q;
    assign quotient = zero_q ? '0 : shreg_q;

endmodule

// File: rtl/ise_param_sorter.sv
// Image sorting engine. Pixels stream in over a valid/ready port; each pixel
// is classified by dominant channel and accumulated per class. After the last
// pixel of an image the dominant class average is computed by a sequential
// divider and the image is insertion-sorted into a register list by
// {colour, average}. After NUM_IMG images the sorted arrival indices stream
// out with backpressure.
// Handshakes: a beat transfers on a rising clk edge where valid && ready are
// both high; valid, once raised, stays high with stable payload until taken.
// Optional feature: define ISE_AVG_OUT_EN to expose the stored average of the
// presented entry on avg_out.
module ise_param_sorter
    import ise_pkg::*;
#(
    parameter int NUM_IMG     = 32,
    parameter int PIX_PER_IMG = 16384,
    parameter int CH_W        = 8,
    parameter int FRAC_W      = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [3*CH_W-1:0]           pixel_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [1:0]                  color_index,
    output logic [$clog2(NUM_IMG)-1:0]  image_out_index,
    output logic                        out_last
`ifdef ISE_AVG_OUT_EN
    ,
    output logic [CH_W+FRAC_W-1:0]      avg_out
`endif
);

    localparam int AVG_W = avg_width(CH_W, FRAC_W);
    localparam int KEY_W = key_width(CH_W, FRAC_W);
    localparam int CNT_W = $clog2(PIX_PER_IMG + 1);
    localparam int SUM_W = CH_W + CNT_W;
    localparam int DVD_W = SUM_W + FRAC_W;
    localparam int IDX_W = $clog2(NUM_IMG);
    localparam int IMG_W = $clog2(NUM_IMG + 1);
    localparam int DC_W  = $clog2(AVG_W);

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] cnt_r, cnt_g, cnt_b;
    logic [SUM_W-1:0] sum_r, sum_g, sum_b;
    logic [IMG_W-1:0] img_cnt;
    logic [DC_W-1:0]  div_cnt;

    logic [KEY_W-1:0] key_q [NUM_IMG];
    logic [IDX_W-1:0] idx_q [NUM_IMG];

    logic [CH_W-1:0]  pix_r, pix_g, pix_b;
    logic [1:0]       pix_cls;
    logic             accept;
    logic             last_pix;
    logic [1:0]       dom;
    logic [SUM_W-1:0] dom_sum;
    logic [CNT_W-1:0] dom_cnt;
    logic             div_start;
    logic             div_done;
    logic [AVG_W-1:0] div_q;
    logic [KEY_W-1:0] new_key;
    logic [IMG_W-1:0] ins_pos;
    logic             ins_en;
    logic             out_xfer;

    assign pix_r = pixel_in[3*CH_W-1:2*CH_W];
    assign pix_g = pixel_in[2*CH_W-1:CH_W];
    assign pix_b = pixel_in[CH_W-1:0];

    assign in_ready  = (state == S_LOAD);
    assign out_valid = (state == S_OUT);
    assign out_last  = (state == S_OUT) && (img_cnt == IMG_W'(1));
    assign accept    = in_valid && in_ready;
    assign last_pix  = accept && (pix_cnt == CNT_W'(PIX_PER_IMG - 1));
    assign out_xfer  = (state == S_OUT) && out_ready;
    assign div_start = (state == S_DIV) && (div_cnt == '0);
    assign ins_en    = (state == S_INS) && div_done;
    assign new_key   = {dom, div_q};

    // Pixel classification: ties favour R, then G.
    always_comb begin
        if (pix_r >= pix_g && pix_r >= pix_b) begin
            pix_cls = COLOR_R;
        end else if (pix_g > pix_r && pix_g >= pix_b) begin
            pix_cls = COLOR_G;
        end else begin
            pix_cls = COLOR_B;
        end
    end

    // Dominant class of the finished image; counters are frozen in DIV/INS,
    // so this stays valid for both the divider operands and the key.
    always_comb begin
        if (cnt_r > cnt_g && cnt_r > cnt_b) begin
            dom = COLOR_R;
        end else if (cnt_g > cnt_b && cnt_g > cnt_r) begin
            dom = COLOR_G;
        end else begin
            dom = COLOR_B;
        end
        unique case (dom)
            COLOR_R: begin dom_sum = sum_r; dom_cnt = cnt_r; end
            COLOR_G: begin dom_sum = sum_g; dom_cnt = cnt_g; end
            default: begin dom_sum = sum_b; dom_cnt = cnt_b; end
        endcase
    end

    ise_seq_div #(
        .DVD_W (DVD_W),
        .DVS_W (CNT_W),
        .Q_W   (AVG_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend ({dom_sum, {FRAC_W{1'b0}}}),
        .divisor  (dom_cnt),
        .done     (div_done),
        .quotient (div_q)
    );

    // Insertion point: number of stored entries whose key is <= the new key,
    // which places the new image after all existing equal keys.
    always_comb begin
        ins_pos = '0;
        for (int i = 0; i < NUM_IMG; i++) begin
            if (IMG_W'(i) < img_cnt && key_q[i] <= new_key) begin
                ins_pos = ins_pos + 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_LOAD: if (last_pix) state_nxt = S_DIV;
            S_DIV:  if (div_cnt == DC_W'(AVG_W - 1)) state_nxt = S_INS;
            S_INS:  state_nxt = (img_cnt == IMG_W'(NUM_IMG - 1)) ? S_OUT : S_LOAD;
            S_OUT:  if (out_xfer && img_cnt == IMG_W'(1)) state_nxt = S_LOAD;
            default: state_nxt = S_LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_LOAD;
        else     state <= state_nxt;
    end

    // Pixel counter within the current image.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt <= '0;
        end else if (accept) begin
            pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
        end
    end

    // Per-class counts and channel sums; cleared once the image is inserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0; cnt_g <= '0; cnt_b <= '0;
            sum_r <= '0; sum_g <= '0; sum_b <= '0;
        end else if (state == S_INS) begin
            cnt_r <= '0; cnt_g <= '0; cnt_b <= '0;
            sum_r <= '0; sum_g <= '0; sum_b <= '0;
        end else if (accept) begin
            unique case (pix_cls)
                COLOR_R: begin cnt_r <= cnt_r + 1'b1; sum_r <= sum_r + SUM_W'(pix_r); end
                COLOR_G: begin cnt_g <= cnt_g + 1'b1; sum_g <= sum_g + SUM_W'(pix_g); end
                default: begin cnt_b <= cnt_b + 1'b1; sum_b <= sum_b + SUM_W'(pix_b); end
            endcase
        end
    end

    // Cycle counter for the division phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 div_cnt <= '0;
        else if (state == S_DIV) div_cnt <= div_cnt + 1'b1;
        else                     div_cnt <= '0;
    end

    // Image counter: counts up while loading, doubles as remaining-entry
    // count while streaming out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            img_cnt <= '0;
        end else if (state == S_INS) begin
            img_cnt <= img_cnt + 1'b1;
        end else if (out_xfer) begin
            img_cnt <= img_cnt - 1'b1;
        end
    end

    // Sorted list: parallel insert with upward shift, downward shift on output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_IMG; i++) begin
                key_q[i] <= '0;
                idx_q[i] <= '0;
            end
        end else if (ins_en) begin
            if (ins_pos == '0) begin
                key_q[0] <= new_key;
                idx_q[0] <= img_cnt[IDX_W-1:0];
            end
            for (int i = 1; i < NUM_IMG; i++) begin
                if (IMG_W'(i) == ins_pos) begin
                    key_q[i] <= new_key;
                    idx_q[i] <= img_cnt[IDX_W-1:0];
                end else if (IMG_W'(i) > ins_pos) begin
                    key_q[i] <= key_q[i-1];
                    idx_q[i] <= idx_q[i-1];
                end
            end
        end else if (out_xfer) begin
            for (int i = 0; i < NUM_IMG - 1; i++) begin
                key_q[i] <= key_q[i+1];
                idx_q[i] <= idx_q[i+1];
            end
            key_q[NUM_IMG-1] <= '0;
            idx_q[NUM_IMG-1] <= '0;
        end
    end

    assign color_index     = key_q[0][KEY_W-1:AVG_W];
    assign image_out_index = idx_q[0];
`ifdef ISE_AVG_OUT_EN
    assign avg_out         = key_q[0][AVG_W-1:0];
`endif

endmodule

// File: tb/tb_ise_param_sorter.sv
// Bench for ise_param_sorter with NUM_IMG=4, PIX_PER_IMG=4, CH_W=8, FRAC_W=3.
// A batch-level reference model computes each image's class/average from the
// pixel list and the stable ascending order; expected entries are queued
// before the batch is driven and a monitor pops them as the DUT emits.
module tb_ise_param_sorter;

  localparam int N  = 4;
  localparam int P  = 4;
  localparam int CW = 8;
  localparam int FW = 3;
  localparam int AW = CW + FW;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3*CW-1:0]   pixel_in;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        color_index;
  logic [1:0]        image_out_index;
  logic              out_last;
`ifdef ISE_AVG_OUT_EN
  logic [AW-1:0]     avg_out;
`endif

  ise_param_sorter #(
    .NUM_IMG     (N),
    .PIX_PER_IMG (P),
    .CH_W        (CW),
    .FRAC_W      (FW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .pixel_in        (pixel_in),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .color_index     (color_index),
    .image_out_index (image_out_index),
    .out_last        (out_last)
`ifdef ISE_AVG_OUT_EN
    ,
    .avg_out         (avg_out)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];   // {colour[1:0], index[1:0], last, avg[10:0]}
  logic [23:0] pix [N*P];
  int rdy_mode = 0;        // 0: always ready, 1: random, 2: 1,0,0,1 pattern

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic build_expected();
    int col [N];
    int avg [N];
    int key [N];
    bit used [N];
    for (int im = 0; im < N; im++) begin
      int cnt [3];
      int sum [3];
      int dm;
      for (int c = 0; c < 3; c++) begin cnt[c] = 0; sum[c] = 0; end
      for (int p = 0; p < P; p++) begin
        int r, g, b;
        r = int'(pix[im*P+p][23:16]);
        g = int'(pix[im*P+p][15:8]);
        b = int'(pix[im*P+p][7:0]);
        if (r >= g && r >= b)      begin cnt[0]++; sum[0] += r; end
        else if (g > r && g >= b)  begin cnt[1]++; sum[1] += g; end
        else                       begin cnt[2]++; sum[2] += b; end
      end
      if (cnt[0] > cnt[1] && cnt[0] > cnt[2])      dm = 0;
      else if (cnt[1] > cnt[2] && cnt[1] > cnt[0]) dm = 1;
      else                                          dm = 2;
      col[im]  = dm;
      avg[im]  = (cnt[dm] == 0) ? 0 : (sum[dm] * (1 << FW)) / cnt[dm];
      key[im]  = dm * (1 << AW) + avg[im];
      used[im] = 1'b0;
    end
    // Repeatedly take the smallest key; scanning in arrival order and
    // requiring strictly smaller keeps equal keys in arrival order.
    for (int k = 0; k < N; k++) begin
      int best;
      logic [15:0] e;
      best = -1;
      for (int j = 0; j < N; j++) begin
        if (!used[j] && (best < 0 || key[j] < key[best])) best = j;
      end
      used[best] = 1'b1;
      e = {2'(col[best]), 2'(best), (k == N - 1), 11'(avg[best])};
      exp_q.push_back(e);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_pix(input int i, input int r, input int g, input int b);
    pix[i] = {8'(r), 8'(g), 8'(b)};
  endtask

  function automatic logic [7:0] rand_ch();
    if ($urandom_range(0, 2) == 0) return 8'($urandom_range(0, 255));
    return 8'($urandom_range(0, 4));
  endfunction

  task automatic gen_random_batch();
    for (int i = 0; i < N * P; i++) pix[i] = {rand_ch(), rand_ch(), rand_ch()};
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_pix(input logic [23:0] p);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    pixel_in = p;
    @(negedge clk);
    while (!in_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) check("in_ready_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pixel_in = 24'($urandom);
  endtask

  // After a non-final image: offer junk pixels while busy (must not be taken)
  // and measure how many cycles in_ready stays low.
  task automatic check_busy_window();
    int low;
    low = 0;
    in_valid = 1'b1;
    pixel_in = 24'($urandom);
    @(negedge clk);
    while (!in_ready && low < 200) begin
      low++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("busy_cycles", 32'(low), 32'(AW + 1));
    @(posedge clk);
    #1;
  endtask

  task automatic drive_batch(input int limit, input int gap_max);
    for (int k = 0; k < limit; k++) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
      send_pix(pix[k]);
      if ((k % P) == P - 1 && (k / P) != N - 1) check_busy_window();
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- out_ready driver ----------------
  initial begin
    int ph;
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = (ph % 4 == 0) || (ph % 4 == 3);
        default: out_ready = 1'b1;
      endcase
      ph++;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic        held_pending;
    logic [15:0] held;
    logic [15:0] act;
    logic [15:0] e;
    held_pending = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      act = {color_index, image_out_index, out_last, 11'd0};
`ifdef ISE_AVG_OUT_EN
      act[10:0] = avg_out;
`endif
      if (rst) begin
        held_pending = 1'b0;
      end else begin
        if (held_pending) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_hold", 32'(act), 32'(held));
        end
        if (out_valid && out_ready) begin
          held_pending = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_out", 32'(act), 32'hFFFF);
          end else begin
            e = exp_q.pop_front();
            check("entry", 32'(act[15:11]), 32'(e[15:11]));
`ifdef ISE_AVG_OUT_EN
            check("entry_avg", 32'(act[10:0]), 32'(e[10:0]));
`endif
          end
        end else if (out_valid) begin
          held_pending = 1'b1;
          held = act;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    pixel_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_color", 32'(color_index), 32'd0);
    check("rst_index", 32'(image_out_index), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
`ifdef ISE_AVG_OUT_EN
    check("rst_avg", 32'(avg_out), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // G avg 8, R avg 200, B avg 8, R avg 8 -> order 3,1,0,2
    for (int p = 0; p < P; p++) begin
      set_pix(0 * P + p, 0, 1, 0);
      set_pix(1 * P + p, 25, 0, 0);
      set_pix(2 * P + p, 0, 0, 1);
      set_pix(3 * P + p, 1, 0, 0);
    end
    build_expected();
    rdy_mode = 0;
    drive_batch(N * P, 0);

    // R avg 26 (sum 10 / 3), B with zero count, two equal G keys.
    set_pix(0, 3, 0, 0); set_pix(1, 3, 0, 0); set_pix(2, 4, 0, 0); set_pix(3, 0, 5, 0);
    set_pix(4, 5, 0, 0); set_pix(5, 5, 0, 0); set_pix(6, 0, 5, 0); set_pix(7, 0, 5, 0);
    for (int p = 0; p < P; p++) begin
      set_pix(2 * P + p, (p == 3) ? 9 : 0, (p == 3) ? 0 : 9, 0);
      set_pix(3 * P + p, (p == 3) ? 9 : 0, (p == 3) ? 0 : 9, 0);
    end
    build_expected();
    rdy_mode = 2;
    drive_batch(N * P, 3);
    build_expected();
    drive_batch(N * P, 0);
    wait_drain();

    // Reset in the middle of loading image 2, then a fresh batch.
    gen_random_batch();
    rdy_mode = 0;
    drive_batch(2 * P + 2, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int b = 0; b < 20; b++) begin
      gen_random_batch();
      build_expected();
      rdy_mode = b % 3;
      drive_batch(N * P, (b % 2 == 1) ? 3 : 0);
    end
    wait_drain();
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
